// File: rtl/rv_mem_pkg.sv
// Shared types for the LSU memory stage: memory-op encoding, RV funct3 load/store
// sizes, FSM states and small decode helpers.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } access_width_e;

  // Reserved funct3 encodings fall through to a full-word access.
  function automatic access_width_e decode_width(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (decode_width(f3))
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / lane-replicated write data, and
// load lane extraction with sign or zero extension.
module lsu_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  access_width_e width;
  logic [1:0]    lane_off;
  logic [31:0]   lane;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    width    = decode_width(size);
    lane_off = 2'b00;
    be       = 4'b1111;
    wdata    = st_data;
    case (width)
      SZ_B: begin
        lane_off = off;
        be       = 4'b0001 << off;
        wdata    = {4{st_data[7:0]}};
      end
      SZ_H: begin
        lane_off = {off[1], 1'b0};
        be       = 4'b0011 << lane_off;
        wdata    = {2{st_data[15:0]}};
      end
      default: ;
    endcase

    lane    = ld_word >> {lane_off, 3'b000};
    ld_data = lane;
    case (width)
      SZ_B: ld_data = size[2] ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      SZ_H: ld_data = size[2] ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: single-outstanding req/gnt/rvalid data bus, write-back
// bundle generation and stall request. Optional MEM_MISALIGN_TRAP_EN adds traps.
module lsu_mem_stage
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_sync,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_mem_op,
  input  logic [2:0]  ex_mem_size,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_reg_waddr,
  input  logic [31:0] ex_reg_wdata,
  input  logic        ex_reg_wen,
  output logic        stall_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        wb_wen,
  output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap,
  output logic [31:0] misalign_addr
`endif
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  lsu_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        wen_q, wen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_waddr_q, wb_waddr_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic        wb_wen_q, wb_wen_d;
  logic        bus_err_q, bus_err_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        trap_q, trap_d;
  logic [31:0] trap_addr_q, trap_addr_d;
`endif

  mem_op_e     op;
  logic [2:0]  align_size;
  logic [1:0]  align_off;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_ld;

  // One aligner: fed from EX at accept time, from the captured access at completion.
  assign align_size = (state_q == ST_IDLE) ? ex_mem_size : size_q;
  assign align_off  = (state_q == ST_IDLE) ? ex_mem_addr[1:0] : off_q;

  lsu_align u_align (
    .size    (align_size),
    .off     (align_off),
    .st_data (ex_store_data),
    .ld_word (dmem_rdata),
    .be      (align_be),
    .wdata   (align_wdata),
    .ld_data (align_ld)
  );

  always_comb begin
    op          = mem_op_e'(ex_mem_op);
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    size_d      = size_q;
    off_d       = off_q;
    waddr_d     = waddr_q;
    wen_d       = wen_q;
    cnt_d       = cnt_q;
    wb_valid_d  = 1'b0;
    wb_waddr_d  = wb_waddr_q;
    wb_wdata_d  = wb_wdata_q;
    wb_wen_d    = 1'b0;
    bus_err_d   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_d      = 1'b0;
    trap_addr_d = trap_addr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (op == MEM_LOAD || op == MEM_STORE) begin
`ifdef MEM_MISALIGN_TRAP_EN
            if (is_misaligned(ex_mem_size, ex_mem_addr[1:0])) begin
              wb_valid_d  = 1'b1;
              wb_waddr_d  = ex_reg_waddr;
              trap_d      = 1'b1;
              trap_addr_d = ex_mem_addr;
            end else
`endif
            begin
              state_d = ST_REQ;
              req_d   = 1'b1;
              we_d    = (op == MEM_STORE);
              addr_d  = {ex_mem_addr[31:2], 2'b00};
              wdata_d = align_wdata;
              be_d    = align_be;
              size_d  = ex_mem_size;
              off_d   = ex_mem_addr[1:0];
              waddr_d = ex_reg_waddr;
              wen_d   = ex_reg_wen && (ex_reg_waddr != 5'd0);
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_waddr_d = ex_reg_waddr;
            wb_wdata_d = ex_reg_wdata;
            wb_wen_d   = ex_reg_wen && (ex_reg_waddr != 5'd0);
          end
        end
      end

      ST_REQ: begin
        if (dmem_gnt) begin
          req_d = 1'b0;
          cnt_d = '0;
          if (we_q) begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            wb_waddr_d = waddr_q;
          end else if (dmem_rvalid) begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            wb_waddr_d = waddr_q;
            wb_wdata_d = align_ld;
            wb_wen_d   = wen_q;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rvalid) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_waddr_d = waddr_q;
          wb_wdata_d = align_ld;
          wb_wen_d   = wen_q;
        end else if (TIMEOUT_CYC != 0 && cnt_d == CNT_W'(TIMEOUT_CYC)) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_waddr_d = waddr_q;
          bus_err_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge value of every other register, independent of statement order.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      size_q      <= '0;
      off_q       <= '0;
      waddr_q     <= '0;
      wen_q       <= 1'b0;
      cnt_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_waddr_q  <= '0;
      wb_wdata_q  <= '0;
      wb_wen_q    <= 1'b0;
      bus_err_q   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      size_q      <= size_d;
      off_q       <= off_d;
      waddr_q     <= waddr_d;
      wen_q       <= wen_d;
      cnt_q       <= cnt_d;
      wb_valid_q  <= wb_valid_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_wdata_q  <= wb_wdata_d;
      wb_wen_q    <= wb_wen_d;
      bus_err_q   <= bus_err_d;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
`endif
    end
  end

  assign ex_ready   = (state_q == ST_IDLE);
  assign stall_req  = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign wb_valid   = wb_valid_q;
  assign wb_waddr   = wb_waddr_q;
  assign wb_wdata   = wb_wdata_q;
  assign wb_wen     = wb_wen_q;
  assign bus_err    = bus_err_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
  assign misalign_addr = trap_addr_q;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: vector table of single transactions plus
// hand-written sequences for timeout, reset mid-transaction and ignored rvalid.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_sync;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_mem_op;
  logic [2:0]  ex_mem_size;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_reg_waddr;
  logic [31:0] ex_reg_wdata;
  logic        ex_reg_wen;
  logic        stall_req;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_wen;
  logic        bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] misalign_addr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT_CYC(4)) dut (
    .clk           (clk),
    .rst_sync      (rst_sync),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_mem_op     (ex_mem_op),
    .ex_mem_size   (ex_mem_size),
    .ex_mem_addr   (ex_mem_addr),
    .ex_store_data (ex_store_data),
    .ex_reg_waddr  (ex_reg_waddr),
    .ex_reg_wdata  (ex_reg_wdata),
    .ex_reg_wen    (ex_reg_wen),
    .stall_req     (stall_req),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_waddr      (wb_waddr),
    .wb_wdata      (wb_wdata),
    .wb_wen        (wb_wen),
    .bus_err       (bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_trap (misalign_trap),
    .misalign_addr (misalign_addr)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] exp_daddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_dwdata;
    logic [31:0] exp_wb;
    logic        exp_wen;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bundle(input logic [1:0] op, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [4:0] waddr,
                              input logic [31:0] wdata, input logic wen);
    ex_valid      = 1'b1;
    ex_mem_op     = op;
    ex_mem_size   = size;
    ex_mem_addr   = addr;
    ex_store_data = sdata;
    ex_reg_waddr  = waddr;
    ex_reg_wdata  = wdata;
    ex_reg_wen    = wen;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic is_mem;
    logic is_load;
    is_mem  = (v.op == 2'b01) || (v.op == 2'b10);
    is_load = (v.op == 2'b01);
    check($sformatf("v%0d ex_ready_pre", i), 32'(ex_ready), 32'd1);
    drive_bundle(v.op, v.size, v.addr, v.sdata, v.waddr, v.wdata, v.wen);
    tick();
    ex_valid = 1'b0;
    if (is_mem) begin
      for (int c = 0; c <= v.gnt_dly; c++) begin
        check($sformatf("v%0d c%0d dmem_req", i, c), 32'(dmem_req), 32'd1);
        check($sformatf("v%0d c%0d dmem_addr", i, c), dmem_addr, v.exp_daddr);
        check($sformatf("v%0d c%0d dmem_be", i, c), 32'(dmem_be), 32'(v.exp_be));
        check($sformatf("v%0d c%0d dmem_we", i, c), 32'(dmem_we), 32'(!is_load));
        check($sformatf("v%0d c%0d stall_req", i, c), 32'(stall_req), 32'd1);
        if (!is_load)
          check($sformatf("v%0d c%0d dmem_wdata", i, c), dmem_wdata, v.exp_dwdata);
        if (c < v.gnt_dly) tick();
      end
      dmem_gnt    = 1'b1;
      dmem_rvalid = is_load && (v.rv_dly == 0);
      dmem_rdata  = v.rdata;
      tick();
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      check($sformatf("v%0d dmem_req_after_gnt", i), 32'(dmem_req), 32'd0);
      if (is_load && v.rv_dly > 0) begin
        for (int c = 0; c < v.rv_dly; c++) begin
          check($sformatf("v%0d w%0d wb_valid_early", i, c), 32'(wb_valid), 32'd0);
          check($sformatf("v%0d w%0d stall_wait", i, c), 32'(stall_req), 32'd1);
          if (c < v.rv_dly - 1) tick();
        end
        dmem_rvalid = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
      end
    end else begin
      check($sformatf("v%0d dmem_req_alu", i), 32'(dmem_req), 32'd0);
    end
    check($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'd1);
    check($sformatf("v%0d wb_waddr", i), 32'(wb_waddr), 32'(v.waddr));
    check($sformatf("v%0d wb_wen", i), 32'(wb_wen), 32'(v.exp_wen));
    if (!is_mem || is_load)
      check($sformatf("v%0d wb_wdata", i), wb_wdata, v.exp_wb);
    check($sformatf("v%0d ex_ready_post", i), 32'(ex_ready), 32'd1);
    check($sformatf("v%0d stall_post", i), 32'(stall_req), 32'd0);
    tick();
    check($sformatf("v%0d wb_valid_drop", i), 32'(wb_valid), 32'd0);
  endtask

  initial begin
    rst_sync = 1'b0;
    ex_valid = 1'b0; ex_mem_op = '0; ex_mem_size = '0; ex_mem_addr = '0;
    ex_store_data = '0; ex_reg_waddr = '0; ex_reg_wdata = '0; ex_reg_wen = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

    //             op    size    addr          sdata         wa  wdata         wen rdata         g  r  daddr         be       dwdata        wb            wen
    vecs.push_back('{2'b00, 3'b000, 32'h0,       32'h0,        5,  32'h1234,     1, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h1234,     1});
    vecs.push_back('{2'b00, 3'b000, 32'h0,       32'h0,        0,  32'hDEAD,     1, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'hDEAD,     0});
    vecs.push_back('{2'b11, 3'b010, 32'h40,      32'h0,        3,  32'h55,       1, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h55,       1});
    vecs.push_back('{2'b10, 3'b000, 32'h103,     32'hAB,       4,  32'h0,        0, 32'h0,        3, 0, 32'h100,      4'b1000, 32'hABABABAB, 32'h0,        0});
    vecs.push_back('{2'b10, 3'b001, 32'hE2,      32'h12345678, 4,  32'h0,        0, 32'h0,        1, 0, 32'hE0,       4'b1100, 32'h56785678, 32'h0,        0});
    vecs.push_back('{2'b10, 3'b010, 32'h200,     32'hCAFEBABE, 4,  32'h0,        0, 32'h0,        0, 0, 32'h200,      4'b1111, 32'hCAFEBABE, 32'h0,        0});
    vecs.push_back('{2'b10, 3'b110, 32'h10,      32'h01020304, 4,  32'h0,        0, 32'h0,        0, 0, 32'h10,       4'b1111, 32'h01020304, 32'h0,        0});
    vecs.push_back('{2'b01, 3'b000, 32'h101,     32'h0,        7,  32'h0,        1, 32'h000080FF, 0, 0, 32'h100,      4'b0010, 32'h0,        32'hFFFFFF80, 1});
    vecs.push_back('{2'b01, 3'b100, 32'h101,     32'h0,        7,  32'h0,        1, 32'h000080FF, 0, 0, 32'h100,      4'b0010, 32'h0,        32'h00000080, 1});
    vecs.push_back('{2'b01, 3'b101, 32'h102,     32'h0,        8,  32'h0,        1, 32'h80010000, 0, 0, 32'h100,      4'b1100, 32'h0,        32'h00008001, 1});
    vecs.push_back('{2'b01, 3'b001, 32'h102,     32'h0,        8,  32'h0,        1, 32'h80010000, 0, 2, 32'h100,      4'b1100, 32'h0,        32'hFFFF8001, 1});
    vecs.push_back('{2'b01, 3'b010, 32'h304,     32'h0,        9,  32'h0,        1, 32'h11223344, 1, 1, 32'h304,      4'b1111, 32'h0,        32'h11223344, 1});
    vecs.push_back('{2'b01, 3'b010, 32'h308,     32'h0,        0,  32'h0,        1, 32'h99887766, 0, 0, 32'h308,      4'b1111, 32'h0,        32'h99887766, 0});
    vecs.push_back('{2'b01, 3'b000, 32'h3,       32'h0,        10, 32'h0,        1, 32'h7F000000, 0, 0, 32'h0,        4'b1000, 32'h0,        32'h0000007F, 1});
`ifndef MEM_MISALIGN_TRAP_EN
    vecs.push_back('{2'b01, 3'b010, 32'h102,     32'h0,        11, 32'h0,        1, 32'hAABBCCDD, 0, 0, 32'h100,      4'b1111, 32'h0,        32'hAABBCCDD, 1});
`endif

    repeat (2) tick();
    check("rst dmem_req", 32'(dmem_req), 32'd0);
    check("rst dmem_we", 32'(dmem_we), 32'd0);
    check("rst dmem_addr", dmem_addr, 32'd0);
    check("rst dmem_wdata", dmem_wdata, 32'd0);
    check("rst dmem_be", 32'(dmem_be), 32'd0);
    check("rst wb_valid", 32'(wb_valid), 32'd0);
    check("rst wb_waddr", 32'(wb_waddr), 32'd0);
    check("rst wb_wdata", wb_wdata, 32'd0);
    check("rst wb_wen", 32'(wb_wen), 32'd0);
    check("rst bus_err", 32'(bus_err), 32'd0);
    check("rst stall_req", 32'(stall_req), 32'd0);
    check("rst ex_ready", 32'(ex_ready), 32'd1);
    rst_sync = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Back-to-back ALU ops: one write-back per cycle.
    drive_bundle(2'b00, 3'b000, 32'h0, 32'h0, 5'd1, 32'hA1, 1'b1);
    tick();
    check("b2b first wb_wdata", wb_wdata, 32'hA1);
    check("b2b first ex_ready", 32'(ex_ready), 32'd1);
    drive_bundle(2'b00, 3'b000, 32'h0, 32'h0, 5'd2, 32'hB2, 1'b1);
    tick();
    ex_valid = 1'b0;
    check("b2b second wb_valid", 32'(wb_valid), 32'd1);
    check("b2b second wb_waddr", 32'(wb_waddr), 32'd2);
    check("b2b second wb_wdata", wb_wdata, 32'hB2);
    tick();

    // Stray rvalid in IDLE must be ignored.
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    tick();
    dmem_rvalid = 1'b0;
    check("idle rvalid wb_valid", 32'(wb_valid), 32'd0);

    // Timeout: LW granted, rvalid never arrives; bus_err 4 cycles after the grant edge.
    drive_bundle(2'b01, 3'b010, 32'h40, 32'h0, 5'd9, 32'h0, 1'b1);
    tick();
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    for (int c = 1; c < 4; c++) begin
      tick();
      check($sformatf("tmo c%0d bus_err", c), 32'(bus_err), 32'd0);
      check($sformatf("tmo c%0d wb_valid", c), 32'(wb_valid), 32'd0);
    end
    tick();
    check("tmo bus_err", 32'(bus_err), 32'd1);
    check("tmo wb_valid", 32'(wb_valid), 32'd1);
    check("tmo wb_wen", 32'(wb_wen), 32'd0);
    check("tmo ex_ready", 32'(ex_ready), 32'd1);
    tick();
    check("tmo bus_err drop", 32'(bus_err), 32'd0);

    // Reset while REQ: dmem_req drops without waiting for a clock edge.
    drive_bundle(2'b01, 3'b010, 32'h80, 32'h0, 5'd6, 32'h0, 1'b1);
    tick();
    ex_valid = 1'b0;
    check("rstreq dmem_req before", 32'(dmem_req), 32'd1);
    #2;
    rst_sync = 1'b0;
    #1;
    check("rstreq dmem_req", 32'(dmem_req), 32'd0);
    check("rstreq ex_ready", 32'(ex_ready), 32'd1);
    tick();
    rst_sync = 1'b1;
    tick();

    // Reset while WAIT: late rvalid must not produce a write-back.
    drive_bundle(2'b01, 3'b010, 32'h84, 32'h0, 5'd6, 32'h0, 1'b1);
    tick();
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("rstwait stall before", 32'(stall_req), 32'd1);
    #2;
    rst_sync = 1'b0;
    #1;
    check("rstwait stall_req", 32'(stall_req), 32'd0);
    check("rstwait ex_ready", 32'(ex_ready), 32'd1);
    tick();
    rst_sync = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF0000;
    tick();
    dmem_rvalid = 1'b0;
    check("rstwait late rvalid wb_valid", 32'(wb_valid), 32'd0);
    tick();
    check("rstwait late rvalid wb_valid2", 32'(wb_valid), 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    drive_bundle(2'b01, 3'b010, 32'h102, 32'h0, 5'd12, 32'h0, 1'b1);
    tick();
    ex_valid = 1'b0;
    check("trap dmem_req", 32'(dmem_req), 32'd0);
    check("trap misalign_trap", 32'(misalign_trap), 32'd1);
    check("trap misalign_addr", misalign_addr, 32'h102);
    check("trap wb_valid", 32'(wb_valid), 32'd1);
    check("trap wb_wen", 32'(wb_wen), 32'd0);
    check("trap ex_ready", 32'(ex_ready), 32'd1);
    tick();
    check("trap misalign_trap drop", 32'(misalign_trap), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage sitting directly downstream of the execute stage; consumes EX results (ALU write-back data, load/store address, store data) and produces the write-back bundle for the register file.
- Drives a single-outstanding data-memory request/grant/rvalid bus, performs byte-lane steering and load extension, and requests a pipeline stall while a memory transaction is in flight.

Parameters:
- TIMEOUT_CYC, 255, cycles to wait for dmem_rvalid after grant before flagging bus_err; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_sync  in  1  reset, asynchronous, active-low (assert async, deassert synchronized externally)
- ex_valid  in  1  EX bundle valid
- ex_ready  out  1  stage can accept bundle (combinational, =state IDLE)
- ex_mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- ex_mem_size  in  3  RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_mem_addr  in  32  effective address
- ex_store_data  in  32  rs2 value
- ex_reg_waddr  in  5  destination register
- ex_reg_wdata  in  32  ALU result for non-memory ops
- ex_reg_wen  in  1  write enable from EX
- stall_req  out  1  to core controller; high in REQ and WAIT
- dmem_req  out  1  request valid, held until grant
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- wb_valid  out  1  one-cycle write-back pulse
- wb_waddr  out  5  write-back register
- wb_wdata  out  32  write-back data
- wb_wen  out  1  write enable, forced 0 when wb_waddr==0
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_*, bus_err, stall_req all 0; ex_ready=1. Reset mid-transaction drops dmem_req immediately and abandons any pending rvalid.
- FSM IDLE/REQ/WAIT. A bundle is accepted only when ex_valid && state==IDLE; upstream holds the bundle while ex_ready=0.
- Non-memory op: accepted in cycle N; wb_valid=1 in N+1 with ex_reg_* fields; stays in IDLE (back-to-back, 1/cycle).
- Load/store accepted in cycle N: registered request outputs valid from N+1, state REQ. Request fields hold stable until dmem_gnt is sampled high.
- Store on gnt: go to IDLE; wb_valid pulse next cycle with wb_wen=0.
- Load on gnt: go to WAIT. If dmem_rvalid coincides with gnt, complete immediately. On rvalid: extract lane (rdata >> 8*addr[1:0]), sign-extend (B/H) or zero-extend (BU/HU); wb_valid next cycle; go to IDLE.
- dmem_be: B = 0001<<addr[1:0]; H = 0011<<{addr[1],1'b0}; W = 1111.
- dmem_wdata: B = byte replicated x4; H = half replicated x2; W = as-is.
- Timeout counter clears on gnt and increments each cycle in WAIT. When it reaches TIMEOUT_CYC: bus_err and wb_valid (wen=0) pulse, then IDLE.
- dmem_rvalid outside WAIT/REQ-with-gnt is ignored. Reserved sizes (011,110,111) behave as W.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined: adds ports misalign_trap (out 1) and misalign_addr (out 32).
  - H with addr[0]=1, or W with addr[1:0]!=0: no bus request is issued.
  - Next cycle: misalign_trap=1, misalign_addr=ex_mem_addr, wb_valid=1, wb_wen=0; stays IDLE.
- Undefined: no trap ports; H ignores addr[0], W ignores addr[1:0].

Decomposition:
- Package rv_mem_pkg: mem_op enum, funct3 size localparams, FSM state enum.
- Sub-module lsu_align (combinational): computes be/wdata for stores and extract/extend for loads; instantiated once.

Test Plan:
- ALU op, reg 5, wdata 0x1234, wen 1 -> wb_valid next cycle, wb_waddr=5, wb_wdata=0x1234, wb_wen=1, dmem_req never asserted.
- SB addr 0x103, data 0xAB, gnt after 3 cycles -> dmem_addr=0x100, be=1000, wdata=0xABABABAB held 3 cycles; stall_req high throughout; wb_valid with wen=0.
- LB addr 0x101, rdata 0x0000_80FF, gnt+rvalid same cycle -> wb_wdata=0xFFFFFF80. LBU gives 0x00000080. LHU addr 0x102 on rdata 0x8001_0000 gives 0x00008001.
- LW, gnt, no rvalid, TIMEOUT_CYC=4 -> bus_err and wb_valid (wen=0) 4 cycles after gnt; returns to IDLE.
- LW to x0 -> wb_wen=0. Reset asserted in WAIT -> dmem_req=0 and state IDLE immediately; a late rvalid produces no wb_valid.
- With MEM_MISALIGN_TRAP_EN, LW addr 0x102 -> no dmem_req, misalign_trap=1, misalign_addr=0x102.
